// File: rtl/fp16_pkg.sv
// Shared binary16 constants, state encoding and internal unpacked number form
// used by the iterative square and square-root datapaths.
package fp16_pkg;

  localparam logic [15:0]       FP16_QNAN = 16'h7E00;
  localparam logic [15:0]       FP16_PINF = 16'h7C00;
  localparam logic signed [6:0] FP16_BIAS = 7'sd15;
  localparam int                FP16_ITER = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } sq_state_e;

  typedef struct packed {
    logic              sign;
    logic signed [6:0] exp;
    logic [10:0]       mant;
  } fp_unpacked_t;

  // Normal operands only: unbiased exponent plus mantissa with hidden bit.
  function automatic fp_unpacked_t fp16_unpack(input logic [15:0] x);
    fp_unpacked_t u;
    u.sign = x[15];
    u.exp  = $signed({2'b00, x[14:10]}) - FP16_BIAS;
    u.mant = {1'b1, x[9:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp16_square_iter_if.sv
// Start/valid request-result bundle shared by the iterative FP16 units.
interface fp16_square_iter_if;
  logic        start;
  logic [15:0] a;
  logic        busy;
  logic        valid;
  logic [15:0] result;
  logic        ovf;
  logic        unf;

  modport master (output start, a, input busy, valid, result, ovf, unf);
  modport slave  (input start, a, output busy, valid, result, ovf, unf);
endinterface

// File: rtl/fp16_round_pack.sv
// Rounds (RNE) and packs an unbiased exponent plus 11-bit normalized mantissa
// into binary16, denormalizing or saturating to infinity as needed.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic signed [6:0] er,
  input  logic [10:0]       mant,
  input  logic              guard,
  input  logic              sticky,
  output logic [15:0]       res,
  output logic              ovf,
  output logic              unf
);
  logic signed [6:0] biased_s;
  logic [3:0]        shamt_s;
  logic [27:0]       ext_s;
  logic [10:0]       m_s;
  logic              g_s, s_s, inc_s;
  logic [4:0]        exp_s;
  logic [14:0]       mag_s;

  // Denormalize, round to nearest even, and let mantissa carry bump the exponent.
  always_comb begin
    biased_s = er + FP16_BIAS;
    shamt_s  = 4'd0;
    ext_s    = 28'd0;
    m_s      = mant;
    g_s      = guard;
    s_s      = sticky;
    exp_s    = 5'd0;
    inc_s    = 1'b0;
    mag_s    = 15'd0;
    res      = 16'h0000;
    ovf      = 1'b0;
    unf      = 1'b0;
    if (biased_s >= 7'sd31) begin
      res = {sign, FP16_PINF[14:0]};
      ovf = 1'b1;
    end else begin
      if (biased_s <= 7'sd0) begin
        // 1-B stays within 1..14, so 16 spare low bits catch everything shifted out.
        shamt_s = 4'd1 - biased_s[3:0];
        ext_s   = {mant, guard, 16'd0} >> shamt_s;
        m_s     = ext_s[27:17];
        g_s     = ext_s[16];
        s_s     = sticky | (|ext_s[15:0]);
        exp_s   = 5'd0;
      end else begin
        m_s   = mant;
        g_s   = guard;
        s_s   = sticky;
        exp_s = biased_s[4:0];
      end
      inc_s = g_s & (s_s | m_s[0]);
      mag_s = {exp_s, m_s[9:0]} + {14'd0, inc_s};
      res   = {sign, mag_s};
      ovf   = &mag_s[14:10];
      unf   = ~|mag_s[14:10];
    end
  end
endmodule

// File: rtl/fp16_special_detector.sv
// Classifies a binary16 value by its exponent and fraction fields.
module fp16_special_detector (
  input  logic [4:0] exp_field,
  input  logic [9:0] frac_field,
  output logic       is_nan,
  output logic       is_inf,
  output logic       is_sub,
  output logic       is_norm
);
  logic exp_max_s, exp_min_s, frac_nz_s;

  assign exp_max_s = &exp_field;
  assign exp_min_s = ~|exp_field;
  assign frac_nz_s = |frac_field;

  assign is_nan  = exp_max_s & frac_nz_s;
  assign is_inf  = exp_max_s & ~frac_nz_s;
  assign is_sub  = exp_min_s & frac_nz_s;
  assign is_norm = ~exp_max_s & ~exp_min_s;
endmodule

// File: rtl/fp16_square_iter.sv
// Iterative binary16 squarer: shift-add mantissa multiply over ITER cycles,
// then one round/pack cycle. Specials resolve directly from IDLE.
module fp16_square_iter
  import fp16_pkg::*;
#(
  parameter int ITER = FP16_ITER
) (
  input logic               clk,
  input logic               rst,
  fp16_square_iter_if.slave bus
);
  sq_state_e         state_r, state_nx_s;
  fp_unpacked_t      op_r, unp_s;
  logic [21:0]       p_r, p_step_s;
  logic [11:0]       sum_s;
  logic [3:0]        cnt_r;
  logic              is_nan_s, is_inf_s, is_sub_s, is_norm_s;
  logic [15:0]       special_s;
  logic signed [6:0] er_s;
  logic [10:0]       rnd_mant_s;
  logic              rnd_guard_s, rnd_sticky_s;
  logic [15:0]       rp_res_s;
  logic              rp_ovf_s, rp_unf_s;
  logic              busy_nx_s, valid_nx_s, busy_r, valid_r;
  logic [15:0]       result_r;
  logic              ovf_r, unf_r;

  fp16_special_detector u_detect (
    .exp_field (bus.a[14:10]),
    .frac_field(bus.a[9:0]),
    .is_nan    (is_nan_s),
    .is_inf    (is_inf_s),
    .is_sub    (is_sub_s),
    .is_norm   (is_norm_s)
  );

  assign unp_s     = fp16_unpack(bus.a);
  assign special_s = is_nan_s ? FP16_QNAN : (is_inf_s ? FP16_PINF : 16'h0000);

  assign sum_s    = {1'b0, p_r[21:11]} + {1'b0, op_r.mant};
  assign p_step_s = p_r[0] ? {sum_s, p_r[10:1]} : {1'b0, p_r[21:1]};

  // Product in [2^20, 2^22): bit 21 selects the extra exponent step.
  assign er_s         = op_r.exp + op_r.exp + $signed({6'd0, p_r[21]});
  assign rnd_mant_s   = p_r[21] ? p_r[21:11] : p_r[20:10];
  assign rnd_guard_s  = p_r[21] ? p_r[10] : p_r[9];
  assign rnd_sticky_s = p_r[21] ? (|p_r[9:0]) : (|p_r[8:0]);

  fp16_round_pack u_round (
    .sign  (op_r.sign),
    .er    (er_s),
    .mant  (rnd_mant_s),
    .guard (rnd_guard_s),
    .sticky(rnd_sticky_s),
    .res   (rp_res_s),
    .ovf   (rp_ovf_s),
    .unf   (rp_unf_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Next-state logic; start outside IDLE is ignored
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nx_s = is_norm_s ? MUL : DONE;
        else           state_nx_s = IDLE;
      end
      MUL: begin
        if (cnt_r == 4'(ITER - 1)) state_nx_s = RND;
        else                       state_nx_s = MUL;
      end
      RND:     state_nx_s = DONE;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from the next state, registered below
  always_comb begin
    busy_nx_s  = (state_nx_s != IDLE);
    valid_nx_s = (state_nx_s == DONE);
  end

  // Handshake output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      busy_r  <= busy_nx_s;
      valid_r <= valid_nx_s;
    end
  end

  // Operand, product, iteration counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= '0;
      p_r      <= 22'd0;
      cnt_r    <= 4'd0;
      result_r <= 16'h0000;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cnt_r <= 4'd0;
            if (is_norm_s) begin
              // Product sign is a^a: a square is never negative.
              op_r <= '{sign: unp_s.sign ^ unp_s.sign, exp: unp_s.exp, mant: unp_s.mant};
              p_r  <= {11'd0, unp_s.mant};
            end else begin
              result_r <= special_s;
              ovf_r    <= 1'b0;
              unf_r    <= is_sub_s;
            end
          end
        end
        MUL: begin
          p_r   <= p_step_s;
          cnt_r <= cnt_r + 4'd1;
        end
        RND: begin
          result_r <= rp_res_s;
          ovf_r    <= rp_ovf_s;
          unf_r    <= rp_unf_s;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.valid  = valid_r;
  assign bus.result = result_r;
  assign bus.ovf    = ovf_r;
  assign bus.unf    = unf_r;
endmodule
